// File: rtl/cpu_pkg.sv
// Shared RV32I definitions: widths, opcodes, ALU op encoding, control bundle.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
    } ctrl_t;

    // funct7[5] turns ADD into SUB only for register-register ops, but
    // selects SRA for both shift forms.
    function automatic alu_op_t alu_decode(input logic [2:0] funct3,
                                           input logic       funct7_b5,
                                           input logic       is_r);
        case (funct3)
            3'b000:  return (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch, writeback and ID/EX signal bundle for the decode stage.
interface id_stage_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] instr_in;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall_out;
    logic            id_ex_valid;
    logic [XLEN-1:0] id_ex_pc;
    logic [XLEN-1:0] id_ex_rs1_data;
    logic [XLEN-1:0] id_ex_rs2_data;
    logic [XLEN-1:0] id_ex_imm;
    logic [4:0]      id_ex_rs1;
    logic [4:0]      id_ex_rs2;
    logic [4:0]      id_ex_rd;
    ctrl_t           id_ex_ctrl;
    logic            id_ex_illegal;

    modport master (
        output pc_in, instr_in, flush, wb_we, wb_rd, wb_data,
        input  stall_out, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
               id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_ctrl, id_ex_illegal
    );

    modport slave (
        input  pc_in, instr_in, flush, wb_we, wb_rd, wb_data,
        output stall_out, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data,
               id_ex_imm, id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_ctrl, id_ex_illegal
    );

endinterface

// File: rtl/regfile.sv
// 32x32 2R1W register file, x0 hardwired to zero.
// ID_WB_BYPASS_EN: when defined, a read of the register being written this
// cycle returns the write data; otherwise it returns the stored value.
module regfile
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREGS];

    // Writeback port; x0 is never written so it stays zero after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    // Combinational read ports.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
`ifdef ID_WB_BYPASS_EN
        if (ra1 != 5'd0) rd1 = (we && wa == ra1) ? wd : regs[ra1];
        if (ra2 != 5'd0) rd2 = (we && wa == ra2) ? wd : regs[ra2];
`else
        if (ra1 != 5'd0) rd1 = regs[ra1];
        if (ra2 != 5'd0) rd2 = regs[ra2];
`endif
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, register file read, decoder,
// immediate generator, load-use hazard detection and ID/EX register.
// Optional macro ID_WB_BYPASS_EN enables WB->ID bypass in the register file.
module id_stage
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    id_stage_if.slave bus
);

    logic [XLEN-1:0] ifid_pc, ifid_instr;
    logic            ifid_valid;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data;

    assign opcode = ifid_instr[6:0];
    assign rd     = ifid_instr[11:7];
    assign rs1    = ifid_instr[19:15];
    assign rs2    = ifid_instr[24:20];

    regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (bus.wb_we),
        .wa    (bus.wb_rd),
        .wd    (bus.wb_data),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rs1_data),
        .rd2   (rs2_data)
    );

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    // Decode control fields and the format-specific sign-extended immediate.
    always_comb begin
        dec_ctrl    = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec_ctrl.alu_op    = alu_decode(ifid_instr[14:12], ifid_instr[30], 1'b1);
                dec_ctrl.reg_write = 1'b1;
            end
            OP_I: begin
                dec_ctrl.alu_op    = alu_decode(ifid_instr[14:12], ifid_instr[30], 1'b0);
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_LW: begin
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
            end
            OP_SW: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
            end
            OP_BEQ: begin
                dec_ctrl.alu_op = ALU_SUB;
                dec_ctrl.branch = 1'b1;
                dec_imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                           ifid_instr[30:25], ifid_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_ctrl.jump      = 1'b1;
                dec_ctrl.reg_write = 1'b1;
                dec_imm = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                           ifid_instr[20], ifid_instr[30:21], 1'b0};
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    ctrl_t           ex_ctrl;
    logic            ex_illegal;
    logic            stall;

    // Load-use hazard: depends only on pipeline state, never on inputs.
    // rs2 is compared for every format, which is conservative but safe.
    assign stall = ex_valid && ex_ctrl.mem_read && ex_rd != 5'd0 &&
                   (ex_rd == rs1 || ex_rd == rs2);

    // IF/ID: flush beats stall; a stall holds the current instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (bus.flush) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_pc    <= bus.pc_in;
            ifid_instr <= bus.instr_in;
            ifid_valid <= 1'b1;
        end
    end

    // ID/EX: flush or stall inject a bubble, otherwise capture the decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || 1'b0) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            ex_illegal  <= 1'b0;
        end else if (bus.flush || stall) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            ex_illegal  <= 1'b0;
        end else begin
            ex_valid    <= ifid_valid;
            ex_pc       <= ifid_pc;
            ex_rs1_data <= rs1_data;
            ex_rs2_data <= rs2_data;
            ex_imm      <= dec_imm;
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ex_ctrl     <= dec_ctrl;
            ex_illegal  <= dec_illegal;
        end
    end

    assign bus.stall_out      = stall;
    assign bus.id_ex_valid    = ex_valid;
    assign bus.id_ex_pc       = ex_pc;
    assign bus.id_ex_rs1_data = ex_rs1_data;
    assign bus.id_ex_rs2_data = ex_rs2_data;
    assign bus.id_ex_imm      = ex_imm;
    assign bus.id_ex_rs1      = ex_rs1;
    assign bus.id_ex_rs2      = ex_rs2;
    assign bus.id_ex_rd       = ex_rd;
    assign bus.id_ex_ctrl     = ex_ctrl;
    assign bus.id_ex_illegal  = ex_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: reset, decode of each opcode class,
// register file write/read, load-use stall, flush-in-stall, x0, illegal.
module tb_id_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
        bus.pc_in    = pc;
        bus.instr_in = ins;
        step();
    endtask

    // Expected control bundle in struct field order.
    function automatic logic [31:0] cv(input logic [3:0] alu, input logic src, input logic mr,
                                       input logic mw, input logic rw, input logic m2r,
                                       input logic br, input logic jp);
        return {21'b0, alu, src, mr, mw, rw, m2r, br, jp};
    endfunction

    function automatic logic [31:0] ctrl_now();
        return 32'(bus.id_ex_ctrl);
    endfunction

    localparam int NV = 8;
    logic [31:0] v_ins  [NV];
    logic [31:0] v_imm  [NV];
    logic [31:0] v_ctrl [NV];

    initial begin
        v_ins[0] = 32'hFFF00093; v_imm[0] = 32'hFFFFFFFF; v_ctrl[0] = cv(4'd0, 1, 0, 0, 1, 0, 0, 0); // addi x1,x0,-1
        v_ins[1] = 32'h40000093; v_imm[1] = 32'h00000400; v_ctrl[1] = cv(4'd0, 1, 0, 0, 1, 0, 0, 0); // addi, bit30 set
        v_ins[2] = 32'h4030D093; v_imm[2] = 32'h00000403; v_ctrl[2] = cv(4'd7, 1, 0, 0, 1, 0, 0, 0); // srai
        v_ins[3] = 32'h402081B3; v_imm[3] = 32'h00000000; v_ctrl[3] = cv(4'd1, 0, 0, 0, 1, 0, 0, 0); // sub
        v_ins[4] = 32'hFE000EE3; v_imm[4] = 32'hFFFFFFFC; v_ctrl[4] = cv(4'd1, 0, 0, 0, 0, 0, 1, 0); // beq -4
        v_ins[5] = 32'h008000EF; v_imm[5] = 32'h00000008; v_ctrl[5] = cv(4'd0, 0, 0, 0, 1, 0, 0, 1); // jal +8
        v_ins[6] = 32'h0000A103; v_imm[6] = 32'h00000000; v_ctrl[6] = cv(4'd0, 1, 1, 0, 1, 1, 0, 0); // lw
        v_ins[7] = 32'h003130B3; v_imm[7] = 32'h00000000; v_ctrl[7] = cv(4'd9, 0, 0, 0, 1, 0, 0, 0); // sltu

        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = '0;
        bus.pc_in    = '0;
        bus.instr_in = NOP_INSTR;
        step();
        step();
        chk("rst_valid", 32'(bus.id_ex_valid), 0);
        chk("rst_stall", 32'(bus.stall_out), 0);
        chk("rst_pc", bus.id_ex_pc, 0);
        chk("rst_ctrl", ctrl_now(), 0);
        reset = 1'b0;

        // ADDI x1,x0,5 at 0x10
        fetch(32'h10, 32'h00500093);
        fetch(32'h14, NOP_INSTR);
        chk("addi_valid", 32'(bus.id_ex_valid), 1);
        chk("addi_pc", bus.id_ex_pc, 32'h10);
        chk("addi_imm", bus.id_ex_imm, 5);
        chk("addi_rd", 32'(bus.id_ex_rd), 1);
        chk("addi_ctrl", ctrl_now(), cv(4'd0, 1, 0, 0, 1, 0, 0, 0));
        chk("addi_ill", 32'(bus.id_ex_illegal), 0);

        // x5 written on the same edge that ADD x6,x5,x0 is decoded
        fetch(32'h20, 32'h00028333);
        bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        fetch(32'h24, NOP_INSTR);
        bus.wb_we = 1'b0;
`ifdef ID_WB_BYPASS_EN
        chk("wb_same_cycle", bus.id_ex_rs1_data, 32'hDEADBEEF);
`else
        chk("wb_same_cycle", bus.id_ex_rs1_data, 32'h0);
`endif

        // x31 write, then SW x31,8(x5) reads both stored values
        bus.wb_we = 1'b1; bus.wb_rd = 5'd31; bus.wb_data = 32'h12345678;
        fetch(32'h28, NOP_INSTR);
        bus.wb_we = 1'b0;
        fetch(32'h2C, 32'h01F2A423);
        fetch(32'h30, NOP_INSTR);
        chk("sw_rs1", bus.id_ex_rs1_data, 32'hDEADBEEF);
        chk("sw_rs2", bus.id_ex_rs2_data, 32'h12345678);
        chk("sw_imm", bus.id_ex_imm, 8);
        chk("sw_ctrl", ctrl_now(), cv(4'd0, 1, 0, 1, 0, 0, 0, 0));

        // Decode table
        for (int i = 0; i < NV; i++) begin
            fetch(32'h100 + 32'(i) * 8, v_ins[i]);
            fetch(32'h104 + 32'(i) * 8, NOP_INSTR);
            chk($sformatf("tbl%0d_pc", i), bus.id_ex_pc, 32'h100 + 32'(i) * 8);
            chk($sformatf("tbl%0d_imm", i), bus.id_ex_imm, v_imm[i]);
            chk($sformatf("tbl%0d_ctrl", i), ctrl_now(), v_ctrl[i]);
            chk($sformatf("tbl%0d_ill", i), 32'(bus.id_ex_illegal), 0);
        end

        // Load-use: LW x2 then ADD x3,x2,x2
        fetch(32'h200, 32'h0000A103);
        fetch(32'h204, 32'h002101B3);
        chk("lu_stall", 32'(bus.stall_out), 1);
        // a different word is presented so a missing IF/ID hold would show
        fetch(32'h208, NOP_INSTR);
        chk("lu_bubble_valid", 32'(bus.id_ex_valid), 0);
        chk("lu_bubble_ctrl", ctrl_now(), 0);
        chk("lu_stall_one_cycle", 32'(bus.stall_out), 0);
        fetch(32'h20C, NOP_INSTR);
        chk("lu_add_valid", 32'(bus.id_ex_valid), 1);
        chk("lu_add_pc", bus.id_ex_pc, 32'h204);
        chk("lu_add_rd", 32'(bus.id_ex_rd), 3);
        chk("lu_add_rs1", 32'(bus.id_ex_rs1), 2);

        // rd=0 load never stalls; rs2-only match does
        fetch(32'h220, 32'h00002003);
        fetch(32'h224, 32'h000001B3);
        chk("lu_rd0_nostall", 32'(bus.stall_out), 0);
        fetch(32'h230, 32'h0000A103);
        fetch(32'h234, 32'h002001B3);
        chk("lu_rs2_stall", 32'(bus.stall_out), 1);
        fetch(32'h234, 32'h002001B3);
        fetch(32'h238, NOP_INSTR);
        chk("lu_rs2_pc", bus.id_ex_pc, 32'h234);

        // Flush during stall
        fetch(32'h300, 32'h0000A103);
        fetch(32'h304, 32'h002101B3);
        chk("fl_stall_before", 32'(bus.stall_out), 1);
        bus.flush = 1'b1;
        fetch(32'h308, 32'h002101B3);
        bus.flush = 1'b0;
        chk("fl_stall_after", 32'(bus.stall_out), 0);
        chk("fl_bubble_valid", 32'(bus.id_ex_valid), 0);
        fetch(32'h30C, NOP_INSTR);
        chk("fl_ifid_killed", 32'(bus.id_ex_valid), 0);
        fetch(32'h310, NOP_INSTR);
        chk("fl_resume_pc", bus.id_ex_pc, 32'h30C);

        // x0 write ignored, even on the same edge as the read
        fetch(32'h400, 32'h00000333);
        bus.wb_we = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFFFFFF;
        fetch(32'h404, 32'h0000007F);
        bus.wb_we = 1'b0;
        chk("x0_same", bus.id_ex_rs1_data, 0);
        fetch(32'h408, 32'h00000333);
        chk("ill_flag", 32'(bus.id_ex_illegal), 1);
        chk("ill_valid", 32'(bus.id_ex_valid), 1);
        chk("ill_ctrl", ctrl_now(), 0);
        fetch(32'h40C, NOP_INSTR);
        chk("x0_after", bus.id_ex_rs1_data, 0);

        // Reset mid-stall clears pipeline and register file
        bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h0000CAFE;
        fetch(32'h500, NOP_INSTR);
        bus.wb_we = 1'b0;
        fetch(32'h504, 32'h00038333);
        fetch(32'h508, NOP_INSTR);
        chk("x7_written", bus.id_ex_rs1_data, 32'h0000CAFE);
        fetch(32'h510, 32'h0000A103);
        fetch(32'h514, 32'h002101B3);
        chk("rst_pre_stall", 32'(bus.stall_out), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(bus.stall_out), 0);
        chk("rst_mid_valid", 32'(bus.id_ex_valid), 0);
        chk("rst_mid_pc", bus.id_ex_pc, 0);
        chk("rst_mid_rd", 32'(bus.id_ex_rd), 0);
        chk("rst_mid_ctrl", ctrl_now(), 0);
        step();
        reset = 1'b0;
        fetch(32'h600, 32'h00038333);
        fetch(32'h604, 32'h01F2A423);
        chk("rst_x7", bus.id_ex_rs1_data, 0);
        fetch(32'h608, NOP_INSTR);
        chk("rst_x31", bus.id_ex_rs2_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch. It:
- latches the fetched PC and instruction in an IF/ID register;
- reads the 32×32 register file and builds the sign-extended immediate;
- decodes control signals into a registered ID/EX bundle;
- detects load-use hazards and drives the fetch-stage stall.

Register-file writes from writeback land here.

## Interface
- No parameters. Widths are fixed by cpu_pkg: XLEN=32, 32 registers.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- pc_in  in  32  PC of instruction presented by fetch
- instr_in  in  32  instruction word presented by fetch
- flush  in  1  taken branch/jump resolved in EX; kills IF/ID and ID/EX contents
- wb_we  in  1  writeback register-write enable
- wb_rd  in  5  writeback destination index
- wb_data  in  32  writeback data
- stall_out  out  1  load-use stall; wired to fetch stall
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_pc  out  32  PC of that instruction
- id_ex_rs1_data / id_ex_rs2_data  out  32 each  operand values
- id_ex_imm  out  32  sign-extended immediate
- id_ex_rs1 / id_ex_rs2 / id_ex_rd  out  5 each  register indices, for EX forwarding
- id_ex_ctrl  out  ctrl_t  control fields:
  - alu_op[3:0]
  - alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump
- id_ex_illegal  out  1  opcode not in the supported set

## Operation
- **Supported opcodes**
  - R-type 0110011
  - I-ALU 0010011
  - LW 0000011
  - SW 0100011
  - BEQ 1100011
  - JAL 1101111
- Any other opcode: all ctrl fields 0, illegal=1, valid kept.
- **alu_op encoding:** ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
  - R and I types: alu_op from funct3/funct7[5]. funct7[5] selects SUB only for R-type; for shifts (SRA) it applies in both R and I.
  - LW, SW, JAL: alu_op = ADD. BEQ: alu_op = SUB.
- **Immediates:** I, S, B (bit0=0) and J (bit0=0) formats, sign-extended from instr[31]. R-type imm = 0.
- **Register file**
  - 32×32, written on posedge when wb_we && wb_rd != 0.
  - x0 reads 0 always.
  - Reads are combinational on IF/ID rs1 = [19:15] and rs2 = [24:20].
- **Load-use hazard:** stall_out = id_ex_valid && id_ex_ctrl.mem_read && id_ex_rd != 0 && (id_ex_rd == rs1 || id_ex_rd == rs2) of the IF/ID instruction.
  - rs2 is compared even for formats that do not use it. This is conservative and accepted.
- **IF/ID update priority**
  - flush: load NOP 0x00000013, valid=0.
  - else stall_out: hold.
  - else: capture pc_in/instr_in, valid=1.
- **ID/EX update priority**
  - flush or stall_out: bubble (all fields 0, valid=0).
  - else: capture decode of IF/ID.
- **Simultaneous flush and stall:** flush wins. stall_out deasserts the next cycle because ID/EX becomes a bubble.

## Timing
- Latency: instruction on fetch outputs before edge N is in IF/ID after edge N and on id_ex_* after edge N+1.
- stall_out is combinational from IF/ID and ID/EX state, never from inputs. No combinational path exists from flush to stall_out.
- A load-use stall lasts exactly one cycle; the dependent instruction enters ID/EX on the following edge.
- **Reset (asynchronous)**
  - IF/ID = NOP, valid 0.
  - All id_ex_* outputs 0; stall_out 0.
  - All 32 registers cleared to 0.
- Asserting reset mid-stall or mid-flush clears everything immediately. No pending state survives.

## Configuration
- **ID_WB_BYPASS_EN defined:** a read of a register being written the same cycle (wb_we && wb_rd == rs && rs != 0) returns wb_data.
- **ID_WB_BYPASS_EN undefined:** the read returns the stored (old) value. Software or EX forwarding must cover the WB→ID distance.

## Structure
- cpu_pkg holds:
  - opcode localparams
  - alu_op_t enum
  - ctrl_t packed struct
  - NOP_INSTR constant
  - XLEN and NREGS
- Sub-module regfile contains the 2R1W array, x0 handling and the ID_WB_BYPASS_EN logic.
- id_stage holds the pipeline registers, decoder, immediate generator and hazard unit.

## Test plan
- **Reset:** assert reset mid-run → next sample shows all id_ex_* = 0, stall_out = 0, x1..x31 read 0.
- **ADDI decode:** 0x00500093 (ADDI x1,x0,5) at pc 0x10 → after 2 edges: valid=1, pc=0x10, imm=5, rd=1, alu_src=1, reg_write=1, alu_op=ADD.
- **Write/read same cycle:** wb writes x5=0xDEADBEEF on the same edge as ADD x6,x5,x0 (0x00028333) sits in IF/ID → rs1_data=0xDEADBEEF with the macro defined, 0 without.
- **Load-use:** LW x2,0(x1) (0x0000A103) then ADD x3,x2,x2 (0x002101B3) →
  - stall_out=1 for exactly one cycle;
  - one bubble with valid=0 enters ID/EX;
  - pc_in is held;
  - the ADD reaches ID/EX one cycle later.
- **Flush during stall:** flush=1 in the stall cycle → IF/ID = NOP, ID/EX bubble, stall_out=0 next cycle.
- **x0 write and illegal opcode:**
  - wb_we with rd=0, data 0xFFFFFFFF → x0 still reads 0.
  - instr 0x0000007F → illegal=1, all ctrl 0.
